matrix_col_scan: RTL and testbench



---
 rtl/matrix_pkg.sv | 25 ++
 rtl/matrix_col_scan_tick_gen.sv | 31 +++
 rtl/matrix_col_scan.sv | 128 ++++++++++++
 tb/tb_matrix_col_scan.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared sizes, scan FSM state encoding and a column one-hot helper for matrix_col_scan.
// Latency: none, definitions only.
// Backpressure: none.
package matrix_pkg;

  localparam int N_COLS  = 5;
  localparam int N_ROWS  = 7;
  localparam int FRAME_W = 35;
  localparam int COL_W   = 3;

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(N_COLS - 1);

  // BLANK is only reachable when SCAN_BLANK_EN is defined.
  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    BLANK,
    SCAN
  } state_t;

  function automatic logic [N_COLS-1:0] onehot_col(input logic [COL_W-1:0] c);
    return N_COLS'(1) << c;
  endfunction

endpackage

// File: rtl/matrix_col_scan_tick_gen.sv
// Column dwell prescaler: tick is high in the last of every CLK_DIV cycles.
// Latency: tick is decoded combinationally from the registered count.
// Backpressure: none; clr holds the count at 0.
module tick_gen #(
  parameter int CLK_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  // Explicit wrap at CLK_DIV-1 so non-power-of-two dividers never overflow.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/matrix_col_scan.sv
// Time-multiplexes a 35-pixel frame onto a 5x7 LED matrix, one column per CLK_DIV cycles.
// Latency: all outputs registered; frame sampled in LOAD, shown from the following column 0.
// Backpressure: none; en=0 blanks the display next cycle. SCAN_BLANK_EN adds a dark cycle before each column.
module matrix_col_scan
  import matrix_pkg::*;
#(
  parameter int CLK_DIV        = 50000,
  parameter int COL_ACTIVE_LOW = 1,
  parameter int ROW_ACTIVE_LOW = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [FRAME_W-1:0] frame_in,
  output logic [N_COLS-1:0]  col_drv,
  output logic [N_ROWS-1:0]  row_drv,
  output logic [COL_W-1:0]   scan_col,
  output logic               pass_done
);

  localparam logic [N_COLS-1:0] COL_OFF = (COL_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [N_ROWS-1:0] ROW_OFF = (ROW_ACTIVE_LOW != 0) ? '1 : '0;

  state_t             state;
  logic [COL_W-1:0]   col_idx;
  logic [FRAME_W-1:0] frame_q;
  logic               tick;
  logic               scan_clr;

  function automatic logic [N_COLS-1:0] col_on(input logic [COL_W-1:0] c);
    logic [N_COLS-1:0] m;
    m = onehot_col(c);
    return (COL_ACTIVE_LOW != 0) ? ~m : m;
  endfunction

  function automatic logic [N_ROWS-1:0] row_on(input logic [FRAME_W-1:0] f,
                                               input logic [COL_W-1:0]   c);
    logic [N_ROWS-1:0] r;
    r = f[c*N_ROWS +: N_ROWS];
    return (ROW_ACTIVE_LOW != 0) ? ~r : r;
  endfunction

  // Prescaler only runs while a column is actually being displayed.
  assign scan_clr = (state != SCAN) || !en;

  tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (scan_clr),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      col_idx   <= '0;
      frame_q   <= '0;
      col_drv   <= COL_OFF;
      row_drv   <= ROW_OFF;
      scan_col  <= '0;
      pass_done <= 1'b0;
    end else begin
      pass_done <= 1'b0;
      col_drv   <= COL_OFF;
      row_drv   <= ROW_OFF;
      if (!en) begin
        state    <= IDLE;
        col_idx  <= '0;
        scan_col <= '0;
      end else begin
        case (state)
          IDLE: begin
            state    <= LOAD;
            col_idx  <= '0;
            scan_col <= '0;
          end
          LOAD: begin
            frame_q  <= frame_in;
            col_idx  <= '0;
            scan_col <= '0;
`ifdef SCAN_BLANK_EN
            state    <= BLANK;
`else
            state    <= SCAN;
            col_drv  <= col_on('0);
            row_drv  <= row_on(frame_in, '0);
`endif
          end
          BLANK: begin
            state    <= SCAN;
            col_drv  <= col_on(col_idx);
            row_drv  <= row_on(frame_q, col_idx);
            scan_col <= col_idx;
          end
          SCAN: begin
            if (!tick) begin
              col_drv  <= col_on(col_idx);
              row_drv  <= row_on(frame_q, col_idx);
              scan_col <= col_idx;
            end else if (col_idx == LAST_COL) begin
              state     <= LOAD;
              col_idx   <= '0;
              scan_col  <= '0;
              pass_done <= 1'b1;
            end else begin
              col_idx  <= col_idx + 1'b1;
              scan_col <= col_idx + 1'b1;
`ifdef SCAN_BLANK_EN
              state    <= BLANK;
`else
              col_drv  <= col_on(col_idx + 1'b1);
              row_drv  <= row_on(frame_q, col_idx + 1'b1);
`endif
            end
          end
          default: begin
            state    <= IDLE;
            col_idx  <= '0;
            scan_col <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_matrix_col_scan.sv
// Bench for matrix_col_scan: directed scenarios then random en/rst/frame traffic,
// compared every cycle against a pass-position reference model.
module tb_matrix_col_scan;

  localparam int D = 4;
`ifdef SCAN_BLANK_EN
  localparam int P = 5*D + 6;
  localparam bit BLANK_MODE = 1'b1;
`else
  localparam int P = 5*D + 1;
  localparam bit BLANK_MODE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [34:0] frame_in;
  logic [4:0]  col_drv;
  logic [6:0]  row_drv;
  logic [2:0]  scan_col;
  logic        pass_done;

  int checks = 0;
  int errors = 0;

  // k = cycles since the LOAD that started this enable period, -1 when idle
  int          k = -1;
  logic [34:0] frame_m = '0;

  always #5 clk = ~clk;

  matrix_col_scan #(
    .CLK_DIV        (D),
    .COL_ACTIVE_LOW (1),
    .ROW_ACTIVE_LOW (0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .frame_in  (frame_in),
    .col_drv   (col_drv),
    .row_drv   (row_drv),
    .scan_col  (scan_col),
    .pass_done (pass_done)
  );

  task automatic check(input string tag, input logic [34:0] obs, input logic [34:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t k=%0d: got %h expected %h", tag, $time, k, obs, exp);
    end
  endtask

  task automatic step();
    int          o;
    int          c;
    int          r;
    bit          active;
    logic [4:0]  e_col;
    logic [6:0]  e_row;
    logic [2:0]  e_scan;
    logic        e_pd;
    logic [4:0]  one;
    @(posedge clk);
    if (rst || !en) begin
      k = -1;
    end else if (k < 0) begin
      k = 0;
    end else begin
      if (k % P == 0) frame_m = frame_in;
      k++;
    end
    e_col  = 5'b11111;
    e_row  = 7'b0000000;
    e_scan = 3'd0;
    e_pd   = 1'b0;
    if (k >= 0) begin
      o = k % P;
      if (o == 0) begin
        e_pd = (k > 0);
      end else begin
        if (BLANK_MODE) begin
          c = (o - 1) / (D + 1);
          r = (o - 1) % (D + 1);
          active = (r != 0);
        end else begin
          c = (o - 1) / D;
          active = 1'b1;
        end
        e_scan = 3'(c);
        if (active) begin
          one   = 5'b00001;
          e_col = 5'b11111 ^ (one << c);
          e_row = 7'(frame_m >> (c * 7));
        end
      end
    end
    #1;
    check("col_drv", 35'(col_drv), 35'(e_col));
    check("row_drv", 35'(row_drv), 35'(e_row));
    check("scan_col", 35'(scan_col), 35'(e_scan));
    check("pass_done", 35'(pass_done), 35'(e_pd));
  endtask

  initial begin
    rst      = 1'b1;
    en       = 1'b1;
    frame_in = '1;
    repeat (3) step();

    rst      = 1'b0;
    frame_in = 35'h400000001;
    repeat (10) step();
    frame_in = '1;
    repeat (40) step();

    frame_in = 35'h2AAAAAAAA;
    repeat (9) step();
    en = 1'b0;
    repeat (2) step();
    en = 1'b1;
    repeat (30) step();

    repeat (14) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (30) step();

    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) en = ~en;
      else if (r == 3) en = 1'b1;
      rst = (r == 4);
      if (r >= 90) frame_in = 35'({$urandom(), $urandom()});
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
